// File: rtl/inv_sqrt_pkg.sv
// Shared types, FP32 constants and the special-operand classifier for the
// inverse-square-root issue controller.
package inv_sqrt_pkg;

    typedef enum logic [1:0] {
        FLAG_OK      = 2'd0,
        FLAG_INVALID = 2'd1,
        FLAG_DIVZERO = 2'd2,
        FLAG_NAN_IN  = 2'd3
    } flag_t;

    localparam logic [31:0] QNAN  = 32'h7FC0_0000;
    localparam logic [31:0] PINF  = 32'h7F80_0000;
    localparam logic [31:0] NINF  = 32'hFF80_0000;
    localparam logic [31:0] PZERO = 32'h0000_0000;
    localparam logic [31:0] QBIT  = 32'h0040_0000;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;

    // ovr=1 means the core result is discarded in favour of data.
    typedef struct packed {
        logic        ovr;
        logic [31:0] data;
        flag_t       flags;
    } ovr_t;

    function automatic ovr_t classify(input logic [31:0] op);
        ovr_t r;
        r.ovr   = 1'b1;
        r.data  = PZERO;
        r.flags = FLAG_OK;
        if (op[30:23] == 8'hFF && op[22:0] != 23'd0) begin
            r.data  = op | QBIT;
            r.flags = FLAG_NAN_IN;
        end else if (op[30:0] == 31'd0) begin
            r.data  = op[31] ? NINF : PINF;
            r.flags = FLAG_DIVZERO;
        end else if (op[31]) begin
            r.data  = QNAN;
            r.flags = FLAG_INVALID;
        end else if (op != PINF) begin
            r.ovr = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/inv_sqrt_res_fifo.sv
// First-word-fall-through result FIFO with occupancy count and one-cycle flush.
module inv_sqrt_res_fifo
#(
    parameter int W     = 34,
    parameter int DEPTH = 4
) (
    input  logic                         ACLK,
    input  logic                         ARESETN,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  logic [W-1:0]                 i_push_data,
    input  logic                         i_pop,
    output logic [W-1:0]                 o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    always_ff @(posedge ACLK) begin
        if (i_push) r_mem[r_wptr] <= i_push_data;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + AW'(1);
            if (i_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/inv_sqrt_sched.sv
// In-order issue controller for a fixed-latency FP32 inverse-square-root core:
// credit-gated accept, special-case override via a shadow pipe, FWFT result queue.
module inv_sqrt_sched
    import inv_sqrt_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int CORE_LAT  = 8,
    parameter int RES_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic                               ACLK,
    input  logic                               ARESETN,
    input  logic                               op_valid,
    output logic                               op_ready,
    input  logic [DATA_W-1:0]                  op_data,
    output logic                               core_in_valid,
    output logic [DATA_W-1:0]                  core_in_data,
    input  logic                               core_out_valid,
    input  logic [DATA_W-1:0]                  core_out_data,
    output logic                               res_valid,
    input  logic                               res_ready,
    output logic [DATA_W-1:0]                  res_data,
    output logic [1:0]                         res_flags,
    input  logic                               soft_clr,
    output logic                               busy,
    output logic [$clog2(RES_DEPTH+1)-1:0]     inflight,
    output logic                               sync_err,
    output logic [CNT_W-1:0]                   done_cnt,
    output logic [1:0]                         dbg_state
);
    localparam int IW = $clog2(RES_DEPTH+1);
    localparam int FW = DATA_W + 2;

    // Handshakes: a transfer happens on a rising ACLK edge where valid && ready;
    // ready never depends on valid, and valid/data hold until the transfer.
    state_t         r_state;
    logic [IW-1:0]  r_inflight;
    logic           r_sync_err;
    logic [CNT_W-1:0] r_done_cnt;
    logic [CORE_LAT-1:0] r_sh_valid;
    ovr_t           r_sh [CORE_LAT];

    logic [IW-1:0]  w_fifo_count;
    logic [FW-1:0]  w_head;
    logic           w_fifo_empty;
    logic [IW:0]    w_credit_used;
    logic           w_accept;
    logic           w_retire;
    logic           w_pop;
    logic           w_flush;
    ovr_t           w_cls;
    ovr_t           w_tail;
    logic [FW-1:0]  w_push_data;

    // Every accepted operand is guaranteed a FIFO slot before it is issued.
    assign w_credit_used = {1'b0, r_inflight} + {1'b0, w_fifo_count};
    assign op_ready      = ARESETN && (r_state != ST_DRAIN) &&
                           (w_credit_used < (IW+1)'(RES_DEPTH));
    assign w_accept      = op_valid && op_ready;
    assign core_in_valid = w_accept;
    assign core_in_data  = w_accept ? op_data : '0;

    assign w_cls    = classify(op_data);
    assign w_tail   = r_sh[CORE_LAT-1];
    assign w_retire = r_sh_valid[CORE_LAT-1];
    assign w_push_data = {(w_tail.ovr ? w_tail.data : core_out_data), w_tail.flags};

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_sh_valid <= '0;
            for (int i = 0; i < CORE_LAT; i++) r_sh[i] <= '0;
        end else begin
            r_sh_valid[0] <= w_accept;
            r_sh[0]       <= w_cls;
            for (int i = 1; i < CORE_LAT; i++) begin
                r_sh_valid[i] <= r_sh_valid[i-1];
                r_sh[i]       <= r_sh[i-1];
            end
        end
    end

    // Flush happens on the cycle the last drained operation has retired.
    assign w_flush   = (r_state == ST_DRAIN) && (r_inflight == '0);
    assign res_valid = !w_fifo_empty && (r_state != ST_DRAIN);
    assign w_pop     = res_valid && res_ready;
    assign res_data  = res_valid ? w_head[FW-1:2] : '0;
    assign res_flags = res_valid ? w_head[1:0] : 2'b00;

    inv_sqrt_res_fifo #(.W(FW), .DEPTH(RES_DEPTH)) u_fifo (
        .ACLK        (ACLK),
        .ARESETN     (ARESETN),
        .i_flush     (w_flush),
        .i_push      (w_retire),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_fifo_count),
        .o_empty     (w_fifo_empty)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (soft_clr) r_state <= ST_DRAIN;
                          else if (w_accept) r_state <= ST_RUN;
                ST_RUN:   if (soft_clr) r_state <= ST_DRAIN;
                          else if (r_inflight == '0 && w_fifo_empty && !w_accept)
                              r_state <= ST_IDLE;
                ST_DRAIN: if (r_inflight == '0) r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_inflight <= '0;
            r_sync_err <= 1'b0;
            r_done_cnt <= '0;
        end else begin
            if (w_accept && !w_retire)      r_inflight <= r_inflight + IW'(1);
            else if (!w_accept && w_retire) r_inflight <= r_inflight - IW'(1);
            if (core_out_valid != w_retire) r_sync_err <= 1'b1;
            if (w_pop) r_done_cnt <= r_done_cnt + CNT_W'(1);
        end
    end

    assign busy      = (r_state != ST_IDLE) || (r_inflight != '0) || !w_fifo_empty;
    assign inflight  = r_inflight;
    assign sync_err  = r_sync_err;
    assign done_cnt  = r_done_cnt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_inv_sqrt_sched.sv
// Self-checking bench for inv_sqrt_sched with a delay-line core model and a
// result scoreboard fed by an FP32 reference of the override rules.
module tb_inv_sqrt_sched;
    localparam int L = 8;
    localparam int D = 4;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        op_valid, op_ready;
    logic [31:0] op_data;
    logic        core_in_valid;
    logic [31:0] core_in_data;
    logic        core_out_valid;
    logic [31:0] core_out_data;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic [1:0]  res_flags;
    logic        soft_clr, busy, sync_err;
    logic [2:0]  inflight;
    logic [15:0] done_cnt;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int drop_req = 0;
    logic [33:0] exp_q[$];
    logic [31:0] ops_q[$];

    inv_sqrt_sched dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data),
        .core_in_valid(core_in_valid), .core_in_data(core_in_data),
        .core_out_valid(core_out_valid), .core_out_data(core_out_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_flags(res_flags), .soft_clr(soft_clr), .busy(busy),
        .inflight(inflight), .sync_err(sync_err), .done_cnt(done_cnt),
        .dbg_state(dbg_state)
    );

    always #5 ACLK = ~ACLK;

    function automatic real fp32_to_real(input logic [31:0] b);
        int  e = int'(b[30:23]);
        real m = real'(b[22:0]);
        if (e == 0) return m * (2.0 ** (-149));
        return (1.0 + m / 8388608.0) * (2.0 ** (e - 127));
    endfunction

    function automatic logic [31:0] real_to_fp32(input real r);
        logic [63:0] d = $realtobits(r);
        logic [10:0] e = d[62:52] - 11'd896;
        return {1'b0, e[7:0], d[51:29]};
    endfunction

    // Reference core: only meaningful for positive finite non-zero operands.
    function automatic logic [31:0] ref_inv_sqrt(input logic [31:0] x);
        if (!x[31] && x[30:23] != 8'hFF && x[30:0] != 31'd0)
            return real_to_fp32(1.0 / $sqrt(fp32_to_real(x)));
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [33:0] expected(input logic [31:0] op);
        if (op[30:23] == 8'hFF && op[22:0] != 23'd0) return {op | 32'h0040_0000, 2'd3};
        if (op[30:0] == 31'd0) return {(op[31] ? 32'hFF80_0000 : 32'h7F80_0000), 2'd2};
        if (op[31]) return {32'h7FC0_0000, 2'd1};
        if (op == 32'h7F80_0000) return {32'h0, 2'd0};
        return {ref_inv_sqrt(op), 2'd0};
    endfunction

    function automatic logic [31:0] gen_op();
        logic [31:0] r = $urandom;
        logic [7:0]  e = 8'($urandom_range(1, 254));
        case ($urandom_range(0, 9))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return {r[31], 8'hFF, r[22:1], 1'b1};
            3:       return 32'h7F80_0000;
            4:       return 32'hFF80_0000;
            5:       return {1'b1, r[30:0]};
            6:       return {9'd0, r[22:0]};
            default: return {1'b0, e, r[22:0]};
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Core model: CORE_LAT-cycle delay line; drop_req suppresses one valid strobe.
    logic        line_v [L];
    logic [31:0] line_d [L];
    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < L; i++) begin
                line_v[i] <= 1'b0;
                line_d[i] <= 32'h0;
            end
        end else begin
            line_v[0] <= core_in_valid && (drop_req == 0);
            line_d[0] <= ref_inv_sqrt(core_in_data);
            if (core_in_valid && drop_req > 0) drop_req = drop_req - 1;
            for (int i = 1; i < L; i++) begin
                line_v[i] <= line_v[i-1];
                line_d[i] <= line_d[i-1];
            end
        end
    end
    assign core_out_valid = line_v[L-1];
    assign core_out_data  = line_d[L-1];

    // Scoreboard: accepts enqueue expectations, pops compare in order.
    always @(negedge ACLK) begin
        if (ARESETN) begin
            check("inflight_bound", 64'(inflight <= 3'(D)), 64'd1);
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) check("res_unexpected", 64'(exp_q.size()), 64'd1);
                else check("res", {30'd0, res_data, res_flags}, {30'd0, exp_q.pop_front()});
            end
            if (op_valid && op_ready) begin
                check("core_in", {31'd0, core_in_valid, core_in_data}, {31'd0, 1'b1, op_data});
                exp_q.push_back(expected(op_data));
            end
        end
    end

    task automatic send_list(input int budget, output int acc);
        acc = 0;
        for (int c = 0; c < budget && ops_q.size() > 0; c++) begin
            @(posedge ACLK); #1;
            op_valid = 1'b1;
            op_data  = ops_q[0];
            @(negedge ACLK);
            if (op_ready) begin
                acc++;
                ops_q.delete(0);
            end
        end
        @(posedge ACLK); #1;
        op_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int ok = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge ACLK);
            if (exp_q.size() == 0 && !busy) begin
                ok = 1;
                break;
            end
        end
        check(tag, 64'(ok), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2, k, base;
        ARESETN = 1'b0; op_valid = 1'b0; op_data = 32'h0;
        res_ready = 1'b1; soft_clr = 1'b0;
        repeat (3) @(negedge ACLK);
        check("rst_op_ready", 64'(op_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_done_cnt", 64'(done_cnt), 64'd0);
        ARESETN = 1'b1;
        @(negedge ACLK);
        check("idle_state", 64'(dbg_state), 64'd0);
        check("idle_op_ready", 64'(op_ready), 64'd1);

        // 1) 4.0 -> 0.5, latency CORE_LAT+1
        @(posedge ACLK); #1;
        op_valid = 1'b1; op_data = 32'h4080_0000;
        @(negedge ACLK);
        check("t1_accept", 64'(op_ready), 64'd1);
        @(posedge ACLK); #1;
        op_valid = 1'b0;
        k = 1;
        for (int c = 0; c < 30; c++) begin
            @(negedge ACLK);
            if (res_valid) break;
            k++;
        end
        check("t1_latency", 64'(k), 64'(L + 1));
        check("t1_data", {32'd0, res_data}, 64'h3F00_0000);
        check("t1_flags", 64'(res_flags), 64'd0);
        @(negedge ACLK);
        check("t1_done_cnt", 64'(done_cnt), 64'd1);

        // 2) special operands, in order
        ops_q = '{32'hBF80_0000, 32'h0000_0000, 32'h8000_0000, 32'h7F80_0001};
        send_list(20, acc);
        check("t2_accepts", 64'(acc), 64'd4);
        wait_idle("t2_idle", 60);

        // random mix through the scoreboard
        for (int i = 0; i < 40; i++) ops_q.push_back(gen_op());
        send_list(200, acc);
        check("rand_accepts", 64'(acc), 64'd40);
        wait_idle("rand_idle", 80);

        // 3) blocked consumer: credit stops at RES_DEPTH
        base = int'(done_cnt);
        res_ready = 1'b0;
        for (int i = 0; i < 6; i++) ops_q.push_back(gen_op());
        send_list(20, acc);
        check("t3_accepts", 64'(acc), 64'(D));
        @(negedge ACLK);
        check("t3_op_ready", 64'(op_ready), 64'd0);
        res_ready = 1'b1;
        send_list(40, acc2);
        check("t3_rest", 64'(acc2), 64'd2);
        wait_idle("t3_idle", 80);
        check("t3_done", 64'(done_cnt), 64'(base + 6));

        // 4) soft_clr with 2 queued + 2 in flight
        res_ready = 1'b0;
        for (int i = 0; i < 2; i++) ops_q.push_back(gen_op());
        send_list(10, acc);
        repeat (L + 2) @(negedge ACLK);
        check("t4_queued", 64'(res_valid), 64'd1);
        for (int i = 0; i < 2; i++) ops_q.push_back(gen_op());
        send_list(10, acc);
        check("t4_accepts", 64'(acc), 64'd2);
        soft_clr = 1'b1;
        @(posedge ACLK); #1;
        soft_clr = 1'b0;
        base = int'(done_cnt);
        k = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge ACLK);
            if (dbg_state == 2'd0) begin
                k = 1;
                break;
            end
            check("t4_op_ready", 64'(op_ready), 64'd0);
            check("t4_res_valid", 64'(res_valid), 64'd0);
        end
        check("t4_idle", 64'(k), 64'd1);
        check("t4_inflight", 64'(inflight), 64'd0);
        check("t4_busy", 64'(busy), 64'd0);
        check("t4_fifo_empty", 64'(res_valid), 64'd0);
        check("t4_done", 64'(done_cnt), 64'(base));
        exp_q.delete();
        res_ready = 1'b1;

        // 5) dropped core strobe -> sticky sync_err
        check("t5_sync_clear", 64'(sync_err), 64'd0);
        drop_req = 1;
        ops_q.push_back(32'h4180_0000);
        send_list(10, acc);
        wait_idle("t5_idle", 40);
        check("t5_sync_set", 64'(sync_err), 64'd1);
        for (int i = 0; i < 3; i++) ops_q.push_back(gen_op());
        send_list(30, acc);
        wait_idle("t5_idle2", 40);
        check("t5_sync_sticky", 64'(sync_err), 64'd1);

        // asynchronous reset mid-burst
        for (int i = 0; i < 6; i++) ops_q.push_back(gen_op());
        send_list(6, acc);
        ops_q.delete();
        op_valid = 1'b1; op_data = 32'h4080_0000;
        #2 ARESETN = 1'b0;
        #1;
        check("ar_op_ready", 64'(op_ready), 64'd0);
        check("ar_core_in", {31'd0, core_in_valid, core_in_data}, 64'd0);
        check("ar_res", {29'd0, res_valid, res_data, res_flags}, 64'd0);
        check("ar_busy", 64'(busy), 64'd0);
        check("ar_inflight", 64'(inflight), 64'd0);
        check("ar_sync_err", 64'(sync_err), 64'd0);
        check("ar_done_cnt", 64'(done_cnt), 64'd0);
        check("ar_state", 64'(dbg_state), 64'd0);
        op_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge ACLK);
        #2 ARESETN = 1'b1;
        @(negedge ACLK);
        check("ar_after", {46'd0, sync_err, done_cnt, busy}, 64'd0);

        // 6) continuous offers: credit limits to RES_DEPTH per CORE_LAT+2 cycles
        for (int i = 0; i < 100; i++) ops_q.push_back(gen_op());
        send_list(100, acc);
        ops_q.delete();
        check("t6_throughput", 64'(acc), 64'(100 / (L + 2) * D));
        wait_idle("t6_idle", 80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
